// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared widths, state encoding and saturation bounds for the CNN datapath
package cnn_pkg;

   localparam int CNN_DATA_W = 8;
   localparam int CNN_ACC_W  = 24;
   localparam int CNN_OUT_W  = 16;
   localparam int CNN_ADDR_W = 19;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

   function automatic longint sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

   localparam longint CNN_SAT_MAX = sat_max(CNN_OUT_W);
   localparam longint CNN_SAT_MIN = sat_min(CNN_OUT_W);

endpackage

// File: rtl/conv_out_fmt.sv
// rtl/conv_out_fmt.sv - combinational ReLU and signed saturation from accumulator to output width
module conv_out_fmt
   import cnn_pkg::*;
#(
   parameter int ACC_W   = CNN_ACC_W,
   parameter int OUT_W   = CNN_OUT_W,
   parameter bit RELU_EN = 1'b1
) (
   input  logic signed [ACC_W-1:0] sum,
   output logic signed [OUT_W-1:0] res,
   output logic                    sat
);

   localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_max(OUT_W));
   localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_min(OUT_W));

   always_comb begin
      res = sum[OUT_W-1:0];
      sat = 1'b0;
      if (RELU_EN && sum[ACC_W-1]) begin
         res = '0;
      end else if (sum > HI) begin
         res = HI[OUT_W-1:0];
         sat = 1'b1;
      end else if (sum < LO) begin
         res = LO[OUT_W-1:0];
         sat = 1'b1;
      end
   end

endmodule

// File: rtl/conv_mac_accum.sv
// rtl/conv_mac_accum.sv - pixel x weight MAC with per-patch write-out behind the conv address generator
module conv_mac_accum
   import cnn_pkg::*;
#(
   parameter int DATA_W  = CNN_DATA_W,
   parameter int ACC_W   = CNN_ACC_W,
   parameter int OUT_W   = CNN_OUT_W,
   parameter int ADDR_W  = CNN_ADDR_W,
   parameter int RD_LAT  = 1,
   parameter bit RELU_EN = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     term_valid,
   input  logic                     term_last,
   input  logic [ADDR_W-1:0]        term_waddr,
   input  logic                     conv_end,
   input  logic signed [DATA_W-1:0] pix_data,
   input  logic signed [DATA_W-1:0] wgt_data,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic signed [OUT_W-1:0]  wr_data,
   output logic                     done,
   output logic                     busy,
   output logic [ADDR_W-1:0]        result_count,
   output logic                     ovf
);

   localparam logic [2:0] FLUSH_LAST = 3'(RD_LAT + 1);

   state_e                     state;
   logic                       conv_end_q;
   logic [2:0]                 flush_cnt;

   logic [RD_LAT-1:0]          al_valid;
   logic [RD_LAT-1:0]          al_last;
   logic [ADDR_W-1:0]          al_addr [RD_LAT];

   logic                       m_valid;
   logic                       m_last;
   logic [ADDR_W-1:0]          m_addr;
   logic signed [2*DATA_W-1:0] m_prod;

   logic signed [2*DATA_W-1:0] pix_ext, wgt_ext;
   logic signed [ACC_W-1:0]    acc, prod_ext, sum;
   logic                       acc_ovf;
   logic signed [OUT_W-1:0]    fmt_res;
   logic                       fmt_sat;
   logic                       term_in;

   assign busy     = (state == RUN) || (state == FLUSH);
   assign term_in  = term_valid && enable && (state == RUN);
   assign pix_ext  = {{DATA_W{pix_data[DATA_W-1]}}, pix_data};
   assign wgt_ext  = {{DATA_W{wgt_data[DATA_W-1]}}, wgt_data};
   assign prod_ext = {{(ACC_W-2*DATA_W){m_prod[2*DATA_W-1]}}, m_prod};
   assign sum      = acc + prod_ext;
   // wrap is kept; only a sign flip between same-sign operands is flagged
   assign acc_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

   conv_out_fmt #(.ACC_W(ACC_W), .OUT_W(OUT_W), .RELU_EN(RELU_EN)) u_fmt (
      .sum (sum),
      .res (fmt_res),
      .sat (fmt_sat)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         conv_end_q <= 1'b0;
         flush_cnt  <= '0;
         done       <= 1'b0;
      end else begin
         done       <= 1'b0;
         conv_end_q <= conv_end;
         if (!enable) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: state <= RUN;
               RUN: begin
                  if (conv_end && !conv_end_q) begin
                     state     <= FLUSH;
                     flush_cnt <= '0;
                  end
               end
               FLUSH: begin
                  if (flush_cnt == FLUSH_LAST) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end else begin
                     flush_cnt <= flush_cnt + 3'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         al_valid     <= '0;
         al_last      <= '0;
         for (int i = 0; i < RD_LAT; i++) al_addr[i] <= '0;
         m_valid      <= 1'b0;
         m_last       <= 1'b0;
         m_addr       <= '0;
         m_prod       <= '0;
         acc          <= '0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         result_count <= '0;
         ovf          <= 1'b0;
      end else if (!enable) begin
         // abandon any partial patch; result_count is kept for software
         al_valid <= '0;
         m_valid  <= 1'b0;
         acc      <= '0;
         wr_en    <= 1'b0;
      end else begin
         for (int i = RD_LAT - 1; i > 0; i--) begin
            al_valid[i] <= al_valid[i-1];
            al_last[i]  <= al_last[i-1];
            al_addr[i]  <= al_addr[i-1];
         end
         al_valid[0] <= term_in;
         al_last[0]  <= term_last;
         al_addr[0]  <= term_waddr;

         m_valid <= al_valid[RD_LAT-1];
         m_last  <= al_valid[RD_LAT-1] && al_last[RD_LAT-1];
         m_addr  <= al_addr[RD_LAT-1];
         m_prod  <= pix_ext * wgt_ext;

         wr_en <= 1'b0;
         if (state == IDLE) begin
            result_count <= '0;
            ovf          <= 1'b0;
         end else if (m_valid) begin
            if (acc_ovf || (m_last && fmt_sat)) ovf <= 1'b1;
            if (m_last) begin
               wr_en        <= 1'b1;
               wr_addr      <= m_addr;
               wr_data      <= fmt_res;
               acc          <= '0;
               result_count <= result_count + ADDR_W'(1);
            end else begin
               acc <= sum;
            end
         end
      end
   end

endmodule
